// File: rtl/rom_blitter.sv
// Copies a full-screen background image from ROM into the VGA frame buffer.
// Define BLIT_WINDOW_EN to add a latched, screen-clipped copy rectangle.
module rom_blitter #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int ROM_LATENCY = 1,
  parameter int ADDR_W      = 17
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              sel,
`ifdef BLIT_WINDOW_EN
  input  logic [8:0]        win_x0,
  input  logic [7:0]        win_y0,
  input  logic [8:0]        win_w,
  input  logic [7:0]        win_h,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  output logic [8:0]        x,
  output logic [7:0]        y,
  output logic              plot,
  output logic              ld_back,
  output logic              select_rom,
  output logic              busy,
  output logic              done
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_RUN   | issuing one ROM address per cycle
  // S_DRAIN | waiting ROM_LATENCY cycles for the last pixel to plot
  // S_DONE  | one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [9:0]        W10    = 10'(WIDTH);
  localparam logic [8:0]        H9     = 9'(HEIGHT);
  localparam logic [ADDR_W-1:0] W_STEP = ADDR_W'(WIDTH);

  state_t state, state_nx;

  logic [8:0]        start_x0;
  logic [7:0]        start_y0;
  logic [9:0]        start_w;
  logic [8:0]        start_h;
  logic [ADDR_W-1:0] start_base;

  logic [8:0]        x0_q, x_last_q, col_q;
  logic [7:0]        y_last_q, row_q;
  logic              empty_q, select_q;
  logic [ADDR_W-1:0] row_base_q, addr_q;
  logic [1:0]        drain_cnt;

  logic              pipe_v [ROM_LATENCY];
  logic [8:0]        pipe_x [ROM_LATENCY];
  logic [7:0]        pipe_y [ROM_LATENCY];

  logic issue, last_issue;

`ifdef BLIT_WINDOW_EN
  // Clip the requested rectangle to the screen edge before latching it.
  always_comb begin
    start_x0 = win_x0;
    start_y0 = win_y0;
    start_w  = '0;
    start_h  = '0;
    if ({1'b0, win_x0} < W10)
      start_w = ({1'b0, win_w} < (W10 - {1'b0, win_x0})) ? {1'b0, win_w}
                                                         : (W10 - {1'b0, win_x0});
    if ({1'b0, win_y0} < H9)
      start_h = ({1'b0, win_h} < (H9 - {1'b0, win_y0})) ? {1'b0, win_h}
                                                        : (H9 - {1'b0, win_y0});
  end
`else
  always_comb begin
    start_x0 = '0;
    start_y0 = '0;
    start_w  = W10;
    start_h  = H9;
  end
`endif

  // Constant-coefficient multiply only at start; per-row stepping is additive.
  assign start_base = ADDR_W'(32'(start_y0) * WIDTH);

  assign issue      = (state == S_RUN) && !empty_q;
  assign last_issue = issue && (col_q == x_last_q) && (row_q == y_last_q);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN: begin
        if (empty_q)         state_nx = S_DONE;
        else if (last_issue) state_nx = S_DRAIN;
      end
      S_DRAIN: if (drain_cnt == 2'd0) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      select_q   <= 1'b0;
      x0_q       <= '0;
      x_last_q   <= '0;
      y_last_q   <= '0;
      empty_q    <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      drain_cnt  <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_x[i] <= '0;
        pipe_y[i] <= '0;
      end
    end else begin
      state <= state_nx;

      if (state == S_IDLE && start) begin
        select_q   <= sel;
        x0_q       <= start_x0;
        x_last_q   <= 9'({1'b0, start_x0} + start_w - 10'd1);
        y_last_q   <= 8'({1'b0, start_y0} + start_h - 9'd1);
        empty_q    <= (start_w == '0) || (start_h == '0);
        col_q      <= start_x0;
        row_q      <= start_y0;
        row_base_q <= start_base;
        addr_q     <= start_base + ADDR_W'(start_x0);
      end else if (issue) begin
        if (col_q == x_last_q) begin
          col_q      <= x0_q;
          row_q      <= row_q + 8'd1;
          row_base_q <= row_base_q + W_STEP;
          addr_q     <= row_base_q + W_STEP + ADDR_W'(x0_q);
        end else begin
          col_q  <= col_q + 9'd1;
          addr_q <= addr_q + ADDR_W'(1);
        end
      end

      if (state == S_RUN && state_nx == S_DRAIN)
        drain_cnt <= 2'(ROM_LATENCY - 1);
      else if (state == S_DRAIN && drain_cnt != 2'd0)
        drain_cnt <= drain_cnt - 2'd1;

      // Coordinates travel alongside the ROM read so x/y line up with q.
      pipe_v[0] <= issue;
      pipe_x[0] <= col_q;
      pipe_y[0] <= row_q;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_x[i] <= pipe_x[i-1];
        pipe_y[i] <= pipe_y[i-1];
      end
    end
  end

  assign rom_addr   = addr_q;
  assign x          = pipe_x[ROM_LATENCY-1];
  assign y          = pipe_y[ROM_LATENCY-1];
  assign plot       = pipe_v[ROM_LATENCY-1];
  assign busy       = (state != S_IDLE);
  assign ld_back    = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign select_rom = select_q;

endmodule

// File: tb/tb_rom_blitter.sv
// Scoreboard bench for rom_blitter on a reduced screen size.
module tb_rom_blitter;
  localparam int W = 16;
  localparam int H = 8;
  localparam int L = 2;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        resetn, start, sel;
  logic [16:0] rom_addr;
  logic [8:0]  x;
  logic [7:0]  y;
  logic        plot, ld_back, select_rom, busy, done;

  rom_blitter #(.WIDTH(W), .HEIGHT(H), .ROM_LATENCY(L), .ADDR_W(17)) dut (
    .clk(clk), .resetn(resetn), .start(start), .sel(sel),
    .rom_addr(rom_addr), .x(x), .y(y), .plot(plot), .ld_back(ld_back),
    .select_rom(select_rom), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int px; int py; int pc; logic ps;} pix_t;
  pix_t exp_pix[$];
  int   exp_done[$];
  int   total = 0;
  int   bad = 0;
  logic [16:0] hist [0:3];
  pix_t p;
  int   dc;

  task automatic chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT plots or signals done.
  always @(negedge clk) begin
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = rom_addr;
    if (plot) begin
      if (exp_pix.size() == 0) chk("spurious_plot", 1, 0);
      else begin
        p = exp_pix.pop_front();
        chk("plot_x", int'(x), p.px);
        chk("plot_y", int'(y), p.py);
        chk("plot_cycle", cyc, p.pc);
        chk("plot_select_rom", int'(select_rom), int'(p.ps));
        chk("plot_addr_align", int'(hist[L]), p.py * W + p.px);
        chk("plot_ld_back", int'(ld_back), 1);
      end
    end
    if (done) begin
      if (exp_done.size() == 0) chk("spurious_done", 1, 0);
      else begin
        dc = exp_done.pop_front();
        chk("done_cycle", cyc, dc);
        chk("plots_left_at_done", exp_pix.size(), 0);
      end
    end
  end

  task automatic check_idle_outputs(string tag);
    chk({tag, "_plot"}, int'(plot), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ld_back"}, int'(ld_back), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  task automatic launch(bit s);
    int sc;
    @(posedge clk); #1;
    chk("busy_before_start", int'(busy), 0);
    sel = s; start = 1'b1; sc = cyc;
    for (int yi = 0; yi < H; yi++)
      for (int xi = 0; xi < W; xi++)
        exp_pix.push_back('{xi, yi, sc + 1 + L + yi * W + xi, s});
    exp_done.push_back(sc + 1 + N + L);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("ld_back_after_start", int'(ld_back), 1);
  endtask

  task automatic run_copy(bit s, bit poke, bit toggle);
    int k = 0;
    int poke_at;
    bit got = 0;
    poke_at = $urandom_range(2, N - 10);
    launch(s);
    while (!got && k < N + L + 20) begin
      @(negedge clk);
      if (done) got = 1;
      else begin
        k++;
        start = poke && (k == poke_at);
        if (toggle) sel = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    if (!got) begin
      chk("done_timeout", 0, 1);
      exp_pix.delete();
      exp_done.delete();
    end
    @(posedge clk); #1;
    check_idle_outputs("after_done");
  endtask

  task automatic run_reset(bit s, int cut);
    launch(s);
    repeat (cut) @(negedge clk);
    resetn = 1'b0;
    @(posedge clk); #1;
    exp_pix.delete();
    exp_done.delete();
    check_idle_outputs("after_reset");
    chk("after_reset_rom_addr", int'(rom_addr), 0);
    chk("after_reset_select_rom", int'(select_rom), 0);
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_idle_outputs("reset_settled");
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    chk("reset_rom_addr", int'(rom_addr), 0);
    chk("reset_x", int'(x), 0);
    chk("reset_y", int'(y), 0);
    chk("reset_select_rom", int'(select_rom), 0);
    resetn = 1'b1;

    run_copy(1'b1, 1'b0, 1'b0);
    run_copy(1'b0, 1'b0, 1'b1);
    run_copy(1'b1, 1'b1, 1'b1);
    run_reset(1'b1, $urandom_range(5, N - 5));
    run_copy(1'b0, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if (r == 2) run_reset(1'($urandom_range(0, 1)), $urandom_range(1, N + L));
      run_copy(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queues_drained", exp_pix.size() + exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
